piso_shift_tx: RTL and testbench

Parallel-in, serial-out shift transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per bit-rate strobe on a single serial line, with frame and done indications. It is the sending end of the flip-flop-based serial capture path: its sout/sout_valid feed the D-input of the receiving register chain. It sits between a parallel data source and that serial link, in the single clk domain.

---
 rtl/piso_shift_tx.sv | 131 +++++++++++++
 tb/tb_piso_shift_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
//
// Parallel-in, serial-out shift transmitter. A WIDTH-bit word is accepted over
// a valid/ready handshake while idle, then driven out one bit per shift_en
// strobe on sout, with sout_valid/frame marking the active frame and a
// one-cycle done pulse after the last bit period.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load_valid  in   source presents a word on load_data
//   load_data   in   word to transmit, sampled on the handshake edge
//   load_ready  out  block can accept a word (idle)
//   shift_en    in   bit-rate strobe, one pulse advances one bit
//   sout        out  serial data, 0 outside a frame
//   sout_valid  out  sout carries a frame bit
//   frame       out  high for the whole word transmission
//   done        out  one-cycle pulse after the last bit period
// -----------------------------------------------------------------------------
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame,
  output logic             done
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sreg_reg, sreg_next;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             sout_reg, sout_next;
  logic             frame_reg, frame_next;
  logic             out_bit_next;

  // Direction-dependent pieces: the shift moves data toward the output end
  // with zero fill, and the output bit is taken from that end of the
  // next-state register so sout can be registered alongside the state.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sreg_shifted = {sreg_reg[WIDTH-2:0], 1'b0};
      assign out_bit_next = sreg_next[WIDTH-1];
    end else begin : g_lsb_first
      assign sreg_shifted = {1'b0, sreg_reg[WIDTH-1:1]};
      assign out_bit_next = sreg_next[0];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    sreg_next  = sreg_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (load_valid) begin
          sreg_next  = load_data;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_reg == LAST) begin
            // Last bit period ends: return to idle and pulse done once.
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            sreg_next = sreg_shifted;
            cnt_next  = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are precomputed from next state so they come straight from flops.
    frame_next = (state_next == SHIFT);
    sout_next  = frame_next & out_bit_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      sout_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sreg_reg  <= sreg_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      sout_reg  <= sout_next;
      frame_reg <= frame_next;
    end
  end

  assign load_ready = (state_reg == IDLE);
  assign sout       = sout_reg;
  assign sout_valid = frame_reg;
  assign frame      = frame_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_piso_shift_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_tx
//
// Directed bench for piso_shift_tx. Two instances share clk and rst_n: one
// MSB-first and one LSB-first, both WIDTH=8. Inputs are driven and outputs
// sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_piso_shift_tx;

  logic       clk;
  logic       rst_n;

  logic       m_load_valid, m_load_ready, m_shift_en;
  logic [7:0] m_load_data;
  logic       m_sout, m_sout_valid, m_frame, m_done;

  logic       l_load_valid, l_load_ready, l_shift_en;
  logic [7:0] l_load_data;
  logic       l_sout, l_sout_valid, l_frame, l_done;

  int checks = 0;
  int errors = 0;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (m_load_valid),
    .load_data  (m_load_data),
    .load_ready (m_load_ready),
    .shift_en   (m_shift_en),
    .sout       (m_sout),
    .sout_valid (m_sout_valid),
    .frame      (m_frame),
    .done       (m_done)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (l_load_valid),
    .load_data  (l_load_data),
    .load_ready (l_load_ready),
    .shift_en   (l_shift_en),
    .sout       (l_sout),
    .sout_valid (l_sout_valid),
    .frame      (l_frame),
    .done       (l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_load_ready, m_sout, m_sout_valid, m_frame, m_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_msb got {rdy,sout,sv,frame,done}=%b exp 10000",
               {m_load_ready, m_sout, m_sout_valid, m_frame, m_done});
    end
    checks++;
    if ({l_load_ready, l_sout, l_sout_valid, l_frame, l_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_lsb got {rdy,sout,sv,frame,done}=%b exp 10000",
               {l_load_ready, l_sout, l_sout_valid, l_frame, l_done});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_load_ready !== 1'b1 || m_sout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%b sv=%b exp rdy=1 sv=0", m_load_ready, m_sout_valid);
    end
    $display("reset: outputs cleared asynchronously");
  endtask

  // 0xA5, shift_en held high: eight consecutive bits, then done with load_ready.
  task automatic test_continuous();
    logic [7:0] exp_seq;
    exp_seq = 8'b1010_0101;   // sout order, cycle 1 first (bit 7 first)
    m_load_valid = 1'b1; m_load_data = 8'hA5; m_shift_en = 1'b1;
    @(negedge clk);
    m_load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (m_sout !== exp_seq[7-k] || m_sout_valid !== 1'b1 || m_frame !== 1'b1 ||
          m_done !== 1'b0 || m_load_ready !== 1'b0) begin
        errors++;
        $display("FAIL a5_bit%0d got sout=%b sv=%b frame=%b done=%b rdy=%b exp sout=%b sv=1 frame=1 done=0 rdy=0",
                 k, m_sout, m_sout_valid, m_frame, m_done, m_load_ready, exp_seq[7-k]);
      end
      @(negedge clk);
    end
    checks++;
    if (m_done !== 1'b1 || m_load_ready !== 1'b1 || m_sout_valid !== 1'b0 || m_sout !== 1'b0) begin
      errors++;
      $display("FAIL a5_cycle9 got done=%b rdy=%b sv=%b sout=%b exp 1 1 0 0",
               m_done, m_load_ready, m_sout_valid, m_sout);
    end
    @(negedge clk);
    checks++;
    if (m_done !== 1'b0) begin
      errors++;
      $display("FAIL a5_done_width got done=%b exp 0", m_done);
    end
    m_shift_en = 1'b0;
    $display("frame 0xA5 msb-first continuous complete");
  endtask

  // 0x3C with shift_en every 4th cycle: each bit held 4 cycles, one done.
  task automatic test_slow_strobe();
    logic [7:0] exp_seq;
    int done_cnt;
    exp_seq  = 8'b0011_1100;
    done_cnt = 0;
    m_load_valid = 1'b1; m_load_data = 8'h3C; m_shift_en = 1'b0;
    @(negedge clk);
    m_load_valid = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      m_shift_en = ((c % 4) == 0) && (c <= 32);
      if (m_done === 1'b1) done_cnt++;
      if (c <= 32) begin
        checks++;
        if (m_sout !== exp_seq[7-((c-1)/4)] || m_sout_valid !== 1'b1) begin
          errors++;
          $display("FAIL 3c_cycle%0d got sout=%b sv=%b exp sout=%b sv=1",
                   c, m_sout, m_sout_valid, exp_seq[7-((c-1)/4)]);
        end
      end else if (c == 33) begin
        checks++;
        if (m_done !== 1'b1 || m_sout_valid !== 1'b0) begin
          errors++;
          $display("FAIL 3c_done_cycle got done=%b sv=%b exp done=1 sv=0", m_done, m_sout_valid);
        end
      end
      @(negedge clk);
    end
    m_shift_en = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL 3c_done_count got %0d exp 1", done_cnt);
    end
    $display("frame 0x3C msb-first strobe/4 complete");
  endtask

  // load_valid with 0xFF during a 0x00 frame is ignored until load_ready.
  task automatic test_load_ignored();
    m_load_valid = 1'b1; m_load_data = 8'h00; m_shift_en = 1'b1;
    @(negedge clk);
    m_load_data = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (m_sout !== 1'b0 || m_sout_valid !== 1'b1 || m_load_ready !== 1'b0) begin
        errors++;
        $display("FAIL ign_bit%0d got sout=%b sv=%b rdy=%b exp sout=0 sv=1 rdy=0",
                 k, m_sout, m_sout_valid, m_load_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (m_done !== 1'b1 || m_load_ready !== 1'b1) begin
      errors++;
      $display("FAIL ign_gap got done=%b rdy=%b exp 1 1", m_done, m_load_ready);
    end
    @(negedge clk);
    m_load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (m_sout !== 1'b1 || m_sout_valid !== 1'b1) begin
        errors++;
        $display("FAIL ff_bit%0d got sout=%b sv=%b exp sout=1 sv=1", k, m_sout, m_sout_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (m_done !== 1'b1) begin
      errors++;
      $display("FAIL ff_done got done=%b exp 1", m_done);
    end
    @(negedge clk);
    m_shift_en = 1'b0;
    $display("frame 0x00 then 0xFF: mid-frame load ignored");
  endtask

  // Reset after 3 bits of 0xFF abandons the frame; 0x81 then sends cleanly.
  task automatic test_reset_midframe();
    logic [7:0] exp_seq;
    int done_cnt;
    exp_seq  = 8'b1000_0001;
    done_cnt = 0;
    m_load_valid = 1'b1; m_load_data = 8'hFF; m_shift_en = 1'b1;
    @(negedge clk);
    m_load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (m_sout !== 1'b1) begin
        errors++;
        $display("FAIL rst_pre_bit%0d got sout=%b exp 1", k, m_sout);
      end
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_load_ready, m_sout, m_sout_valid, m_frame, m_done} !== 5'b10000) begin
      errors++;
      $display("FAIL rst_mid got {rdy,sout,sv,frame,done}=%b exp 10000",
               {m_load_ready, m_sout, m_sout_valid, m_frame, m_done});
    end
    @(negedge clk);
    if (m_done === 1'b1) done_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL rst_no_done got %0d done pulses exp 0", done_cnt);
    end
    m_load_valid = 1'b1; m_load_data = 8'h81;
    @(negedge clk);
    m_load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (m_sout !== exp_seq[7-k] || m_sout_valid !== 1'b1) begin
        errors++;
        $display("FAIL 81_bit%0d got sout=%b sv=%b exp sout=%b sv=1",
                 k, m_sout, m_sout_valid, exp_seq[7-k]);
      end
      @(negedge clk);
    end
    checks++;
    if (m_done !== 1'b1) begin
      errors++;
      $display("FAIL 81_done got done=%b exp 1", m_done);
    end
    m_shift_en = 1'b0;
    @(negedge clk);
    $display("frame 0xFF aborted by reset, frame 0x81 complete");
  endtask

  // LSB-first 0x01 then 0x80 with load_valid held high: one idle gap cycle.
  task automatic test_back_to_back();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    exp_a = 8'b1000_0000;   // sout order, first cycle is bit 7 of this vector
    exp_b = 8'b0000_0001;
    l_load_valid = 1'b1; l_load_data = 8'h01; l_shift_en = 1'b1;
    @(negedge clk);
    l_load_data = 8'h80;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (l_sout !== exp_a[7-k] || l_sout_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_a_bit%0d got sout=%b sv=%b exp sout=%b sv=1",
                 k, l_sout, l_sout_valid, exp_a[7-k]);
      end
      @(negedge clk);
    end
    checks++;
    if (l_sout_valid !== 1'b0 || l_done !== 1'b1 || l_load_ready !== 1'b1 || l_sout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got sv=%b done=%b rdy=%b sout=%b exp 0 1 1 0",
               l_sout_valid, l_done, l_load_ready, l_sout);
    end
    @(negedge clk);
    l_load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (l_sout !== exp_b[7-k] || l_sout_valid !== 1'b1 || l_done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_b_bit%0d got sout=%b sv=%b done=%b exp sout=%b sv=1 done=0",
                 k, l_sout, l_sout_valid, l_done, exp_b[7-k]);
      end
      @(negedge clk);
    end
    checks++;
    if (l_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_b_done got done=%b exp 1", l_done);
    end
    l_shift_en = 1'b0;
    @(negedge clk);
    $display("frames 0x01, 0x80 lsb-first back-to-back complete");
  endtask

  initial begin
    m_load_valid = 1'b0; m_load_data = 8'h00; m_shift_en = 1'b0;
    l_load_valid = 1'b0; l_load_data = 8'h00; l_shift_en = 1'b0;
    test_reset();
    test_continuous();
    test_slow_strobe();
    test_load_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
